multi_port_ram: RTL

MULTI_PORT_RAM -- requirements
Module: multi_port_ram

---
 rtl/multi_port_ram_pkg.sv | 12 +
 rtl/multi_port_ram_rr_arbiter.sv | 43 ++++
 rtl/multi_port_ram.sv | 96 +++++++++
 3 files changed

// File: rtl/multi_port_ram_pkg.sv
// Shared defaults for the multi-channel RAM and its byte-enable width helper.
package multi_port_ram_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_N_CH   = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/multi_port_ram_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at the
// priority pointer; the pointer moves past the winner whenever advance is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            win;
  int            idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    // With N == 1 the modulo keeps the pointer pinned at 0.
    if (advance) ptr_d = PW'((win + 1) % N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_port_ram.sv
// Single-port RAM shared by N_CH requesters through a round-robin arbiter;
// one access per cycle, byte-masked writes, reads return one cycle later.
module multi_port_ram
  import multi_port_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_CH   = DEF_N_CH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CH-1:0]                   req_valid,
  output logic [N_CH-1:0]                   req_ready,
  input  logic [N_CH-1:0]                   req_we,
  input  logic [N_CH*ADDR_W-1:0]            req_addr,
  input  logic [N_CH*DATA_W-1:0]            req_wdata,
  input  logic [N_CH*be_width(DATA_W)-1:0]  req_be,
  output logic [N_CH-1:0]                   rsp_valid,
  output logic [DATA_W-1:0]                 rsp_rdata
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [N_CH-1:0]   gnt;
  logic              xfer;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              wr_en, rd_en;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_seen_q, rd_seen_d;
  logic [N_CH-1:0]   rsp_valid_q, rsp_valid_d;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign req_ready = gnt & {N_CH{~rst}};
  assign xfer      = |req_ready;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        sel_we    = req_we[k];
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[k*DATA_W +: DATA_W];
        sel_be    = req_be[k*BE_W +: BE_W];
      end
    end
  end

  assign wr_en = xfer & sel_we;
  assign rd_en = xfer & ~sel_we;

  // Array kept reset-free with a registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (sel_be[i]) mem[sel_addr][i*8 +: 8] <= sel_wdata[i*8 +: 8];
      end
    end
    if (rd_en) rd_q <= mem[sel_addr];
  end

  always_comb begin
    rsp_valid_d = rd_en ? gnt : '0;
    rd_seen_d   = rd_seen_q | rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rd_seen_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  // Masking with rst suppresses the response of a read caught by a reset.
  assign rsp_valid = rsp_valid_q & {N_CH{~rst}};
  assign rsp_rdata = rd_seen_q ? rd_q : '0;

endmodule
